// File: rtl/eth_mii_tx_framer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// eth_mii_tx_framer_if: command, frame-buffer read and MII transmit signals.
// Rev 1.0
//------------------------------------------------------------------------------
interface eth_mii_tx_framer_if #(
   parameter int MTU = 1536
);
   localparam int AW = $clog2(MTU);

   logic          start;
   logic [15:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          tx_tick;
   logic [3:0]    mii_txd;
   logic          mii_tx_en;

   modport master (
      output start, len, rd_data, tx_tick,
      input  busy, done, rd_addr, mii_txd, mii_tx_en
   );

   modport slave (
      input  start, len, rd_data, tx_tick,
      output busy, done, rd_addr, mii_txd, mii_tx_en
   );
endinterface
`default_nettype wire

// File: rtl/eth_mii_tx_framer.sv
`default_nettype none
//------------------------------------------------------------------------------
// eth_mii_tx_framer: serialises a buffered frame onto MII with preamble, pad, FCS, IFG.
// Rev 1.0
//------------------------------------------------------------------------------
module eth_mii_tx_framer #(
   parameter int MTU     = 1536,
   parameter int MIN_LEN = 60,
   parameter int IFG_NIB = 24
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   eth_mii_tx_framer_if.slave bus
);
   localparam int AW = $clog2(MTU);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_PAD  = 3'd3;
   localparam logic [2:0] S_FCS  = 3'd4;
   localparam logic [2:0] S_IFG  = 3'd5;

   localparam logic [31:0] C_POLY     = 32'hEDB88320;
   localparam logic [15:0] C_MTU      = 16'(MTU);
   localparam logic [15:0] C_MIN      = 16'(MIN_LEN);
   localparam logic [15:0] C_MIN_LAST = 16'(MIN_LEN - 1);
   localparam logic [15:0] C_IFG_LAST = 16'(IFG_NIB - 1);

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [15:0]   r_len;
   logic [15:0]   r_bcnt;
   logic [15:0]   r_cnt;
   logic          r_nib;
   logic [7:0]    r_cur;
   logic [7:0]    r_nxt;
   logic          r_rd_req;
   logic          r_rd_vld;
   logic [31:0]   r_crc;
   logic [AW-1:0] r_rd_addr;
   logic          r_busy;
   logic          r_done;
   logic [3:0]    r_txd;
   logic          r_tx_en;

   logic          w_accept;
   logic [15:0]   w_bnext;
   logic          w_last_data;
   logic [31:0]   w_fcs;
   logic [31:0]   w_fcs_sh;
   logic [3:0]    w_txd_nxt;
   logic          w_tx_en_nxt;
   logic          w_crc_upd;

   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] v;
      v = c ^ {28'd0, d};
      for (int i = 0; i < 4; i++)
         v = v[0] ? ((v >> 1) ^ C_POLY) : (v >> 1);
      return v;
   endfunction

   // The cycle that carries `done` still reads as IDLE, so it must not accept a start.
   assign w_accept    = (r_state == S_IDLE) && !r_done && bus.start;
   assign w_bnext     = r_bcnt + 16'd1;
   assign w_last_data = (w_bnext == r_len);
   assign w_fcs       = ~r_crc;
   assign w_fcs_sh    = w_fcs >> {r_cnt[2:0], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_PRE;
         S_PRE:  if (bus.tx_tick && r_cnt == 16'd15)
                    w_state_nxt = (r_len == 16'd0) ? S_PAD : S_DATA;
         S_DATA: if (bus.tx_tick && r_nib && w_last_data)
                    w_state_nxt = (r_len < C_MIN) ? S_PAD : S_FCS;
         S_PAD:  if (bus.tx_tick && r_nib && r_bcnt == C_MIN_LAST) w_state_nxt = S_FCS;
         S_FCS:  if (bus.tx_tick && r_cnt == 16'd7) w_state_nxt = S_IFG;
         S_IFG:  if (bus.tx_tick && r_cnt == C_IFG_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_txd_nxt   = 4'h0;
      w_tx_en_nxt = 1'b0;
      w_crc_upd   = 1'b0;
      case (r_state)
         S_PRE: begin
            w_txd_nxt   = (r_cnt == 16'd15) ? 4'hD : 4'h5;
            w_tx_en_nxt = 1'b1;
         end
         S_DATA: begin
            w_txd_nxt   = r_nib ? r_cur[7:4] : r_nxt[3:0];
            w_tx_en_nxt = 1'b1;
            w_crc_upd   = 1'b1;
         end
         S_PAD: begin
            w_tx_en_nxt = 1'b1;
            w_crc_upd   = 1'b1;
         end
         S_FCS: begin
            w_txd_nxt   = w_fcs_sh[3:0];
            w_tx_en_nxt = 1'b1;
         end
         default: begin
            w_txd_nxt   = 4'h0;
            w_tx_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_bcnt    <= '0;
         r_cnt     <= '0;
         r_nib     <= 1'b0;
         r_cur     <= '0;
         r_nxt     <= '0;
         r_rd_req  <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_crc     <= '1;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_txd     <= 4'h0;
         r_tx_en   <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_rd_vld <= r_rd_req;
         r_rd_req <= 1'b0;
         // rd_data is valid the cycle after rd_addr; capture at the end of that cycle.
         if (r_rd_vld)
            r_nxt <= bus.rd_data;

         if (w_accept) begin
            r_len     <= (bus.len > C_MTU) ? C_MTU : bus.len;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
            r_rd_req  <= 1'b1;
            r_bcnt    <= '0;
            r_cnt     <= '0;
            r_nib     <= 1'b0;
         end

         if (bus.tx_tick && r_state != S_IDLE) begin
            r_txd   <= w_txd_nxt;
            r_tx_en <= w_tx_en_nxt;
            if (w_crc_upd)
               r_crc <= crc_nib(r_crc, w_txd_nxt);
            case (r_state)
               S_PRE: r_cnt <= (r_cnt == 16'd15) ? 16'd0 : r_cnt + 16'd1;
               S_DATA: begin
                  if (!r_nib) begin
                     r_cur <= r_nxt;
                     if (w_bnext < r_len) begin
                        r_rd_addr <= w_bnext[AW-1:0];
                        r_rd_req  <= 1'b1;
                     end
                  end else begin
                     r_bcnt <= w_bnext;
                  end
                  r_nib <= ~r_nib;
               end
               S_PAD: begin
                  if (r_nib)
                     r_bcnt <= w_bnext;
                  r_nib <= ~r_nib;
               end
               S_FCS: r_cnt <= (r_cnt == 16'd7) ? 16'd0 : r_cnt + 16'd1;
               S_IFG: begin
                  if (r_cnt == C_IFG_LAST) begin
                     r_cnt  <= 16'd0;
                     r_done <= 1'b1;
                     r_busy <= 1'b0;
                     r_crc  <= '1;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.mii_txd   = r_txd;
   assign bus.mii_tx_en = r_tx_en;
endmodule
`default_nettype wire

// File: tb/tb_eth_mii_tx_framer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_eth_mii_tx_framer: random frames checked against a byte-level frame/CRC model.
// Rev 1.0
//------------------------------------------------------------------------------
module tb_eth_mii_tx_framer;
   localparam int MTU = 1536;

   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   int   tick_gap = 2;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [7:0]  mem [0:2047];
   logic [3:0]  exp_q[$];
   logic [31:0] exp_fcs;
   logic [3:0]  cap_q[$];
   logic [3:0]  q1[$];
   int cap_en_ticks, cap_ifg_ticks, cap_gap_err, cap_sync_err, cap_busy_err, cap_max_addr;
   bit cap_done;
   bit sel = 1'b0;

   eth_mii_tx_framer_if #(.MTU(MTU)) ifa ();
   eth_mii_tx_framer_if #(.MTU(MTU)) ifb ();

   eth_mii_tx_framer #(.MTU(MTU), .MIN_LEN(9), .IFG_NIB(24)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   eth_mii_tx_framer #(.MTU(MTU), .MIN_LEN(60), .IFG_NIB(24)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   always #5 clk = ~clk;

   assign ifa.tx_tick = tick;
   assign ifb.tx_tick = tick;

   always @(posedge clk) begin
      ifa.rd_data <= mem[ifa.rd_addr];
      ifb.rd_data <= mem[ifb.rd_addr];
   end

   logic [3:0]  m_txd;
   logic        m_en, m_busy, m_done;
   logic [10:0] m_addr;
   assign m_txd  = sel ? ifb.mii_txd   : ifa.mii_txd;
   assign m_en   = sel ? ifb.mii_tx_en : ifa.mii_tx_en;
   assign m_busy = sel ? ifb.busy      : ifa.busy;
   assign m_done = sel ? ifb.done      : ifa.done;
   assign m_addr = sel ? ifb.rd_addr   : ifa.rd_addr;

   // tick_gap==0 selects a random spacing of 2..10 clocks per tick
   initial begin
      tick = 1'b0;
      forever begin
         int gap;
         gap = (tick_gap == 0) ? int'($urandom_range(10, 2)) : tick_gap;
         repeat (gap - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   task automatic fill_random();
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
   endtask

   task automatic build_model(input int len, input int minl);
      int l, tot;
      logic [7:0]  b;
      logic [31:0] crc;
      l   = (len > MTU) ? MTU : len;
      tot = (l > minl) ? l : minl;
      exp_q.delete();
      crc = 32'hFFFFFFFF;
      repeat (15) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      for (int i = 0; i < tot; i++) begin
         b = (i < l) ? mem[i] : 8'h00;
         exp_q.push_back(b[3:0]);
         exp_q.push_back(b[7:4]);
         crc = crc ^ {24'd0, b};
         for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
      end
      exp_fcs = ~crc;
      for (int i = 0; i < 8; i++) exp_q.push_back(exp_fcs[4*i +: 4]);
   endtask

   function automatic int stream_diffs();
      int d = 0;
      if (cap_q.size() != exp_q.size()) d++;
      foreach (exp_q[i]) if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) d++;
      return d;
   endfunction

   function automatic logic [31:0] cap_fcs();
      logic [31:0] f = '0;
      if (cap_q.size() >= 8)
         for (int i = 0; i < 8; i++) f[4*i +: 4] = cap_q[cap_q.size() - 8 + i];
      return f;
   endfunction

   task automatic drive_start(input bit s, input int len);
      if (s) begin ifb.start = 1'b1; ifb.len = 16'(len); end
      else   begin ifa.start = 1'b1; ifa.len = 16'(len); end
   endtask

   // Captures one frame from the selected DUT until done (or the cycle budget runs out).
   task automatic send_frame(input bit s, input int len, input bit do_start, input int mid_cyc);
      int cyc;
      bit seen, fell;
      logic [3:0] ptxd;
      logic pen;
      sel = s;
      cap_q.delete();
      cap_en_ticks = 0; cap_ifg_ticks = 0; cap_gap_err = 0;
      cap_sync_err = 0; cap_busy_err = 0; cap_max_addr = 0; cap_done = 1'b0;
      seen = 1'b0; fell = 1'b0; cyc = 0;
      if (do_start) begin
         @(posedge clk); #1;
         drive_start(s, len);
      end
      ptxd = s ? ifb.mii_txd : ifa.mii_txd;
      pen  = s ? ifb.mii_tx_en : ifa.mii_tx_en;
      while (!cap_done && cyc < 40000) begin
         @(posedge clk); #1;
         cyc++;
         ifa.start = 1'b0;
         ifb.start = 1'b0;
         if (cyc == mid_cyc) drive_start(s, 3);
         if (int'(m_addr) > cap_max_addr) cap_max_addr = int'(m_addr);
         if (!tick && (m_txd !== ptxd || m_en !== pen)) cap_sync_err++;
         if (tick) begin
            if (m_en) begin
               if (fell) cap_gap_err++;
               seen = 1'b1;
               cap_q.push_back(m_txd);
               cap_en_ticks++;
            end else if (seen) begin
               fell = 1'b1;
               cap_ifg_ticks++;
            end
         end
         if (m_done) cap_done = 1'b1;
         else if (!m_busy) cap_busy_err++;
         ptxd = m_txd;
         pen  = m_en;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifa.start = 1'b0; ifb.start = 1'b0; ifa.len = '0; ifb.len = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", s, m_busy); end
         n_chk++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d: got %b want 0", s, m_done); end
         n_chk++; if (m_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr dut%0d: got %0d want 0", s, m_addr); end
         n_chk++; if (m_txd !== 4'h0) begin n_fail++; $display("FAIL reset_txd dut%0d: got %h want 0", s, m_txd); end
         n_chk++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en dut%0d: got %b want 0", s, m_en); end
      end
   endtask

   task automatic test_check_vector();
      tick_gap = 2;
      for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
      send_frame(1'b0, 9, 1'b1, 0);
      build_model(9, 9);
      n_chk++; if (!cap_done) begin n_fail++; $display("FAIL vec_done: no done within budget"); end
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL vec_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_fcs() !== 32'hCBF43926) begin n_fail++; $display("FAIL vec_fcs: got %h want cbf43926", cap_fcs()); end
      n_chk++; if (cap_en_ticks != 42) begin n_fail++; $display("FAIL vec_tx_en_len: got %0d want 42", cap_en_ticks); end
      n_chk++; if (cap_ifg_ticks != 24) begin n_fail++; $display("FAIL vec_ifg: got %0d want 24", cap_ifg_ticks); end
      n_chk++; if (cap_gap_err != 0 || cap_sync_err != 0) begin n_fail++;
         $display("FAIL vec_timing: gaps %0d off-tick changes %0d want 0/0", cap_gap_err, cap_sync_err); end
   endtask

   task automatic test_short_pad();
      fill_random();
      tick_gap = 0;
      send_frame(1'b1, 14, 1'b1, 0);
      build_model(14, 60);
      n_chk++; if (!cap_done) begin n_fail++; $display("FAIL pad_done: no done within budget"); end
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL pad_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_fcs() !== exp_fcs) begin n_fail++; $display("FAIL pad_fcs: got %h want %h", cap_fcs(), exp_fcs); end
      n_chk++; if (cap_en_ticks != 144) begin n_fail++; $display("FAIL pad_tx_en_len: got %0d want 144", cap_en_ticks); end
      n_chk++; if (cap_ifg_ticks != 24) begin n_fail++; $display("FAIL pad_ifg: got %0d want 24", cap_ifg_ticks); end
   endtask

   task automatic test_zero_len();
      fill_random();
      tick_gap = 0;
      send_frame(1'b1, 0, 1'b1, 0);
      build_model(0, 60);
      n_chk++; if (!cap_done) begin n_fail++; $display("FAIL zero_done: no done within budget"); end
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL zero_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_en_ticks != 144) begin n_fail++; $display("FAIL zero_tx_en_len: got %0d want 144", cap_en_ticks); end
   endtask

   task automatic test_clamp();
      fill_random();
      tick_gap = 2;
      send_frame(1'b1, 2000, 1'b1, 0);
      build_model(2000, 60);
      n_chk++; if (!cap_done) begin n_fail++; $display("FAIL clamp_done: no done within budget"); end
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL clamp_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_max_addr > 1535) begin n_fail++; $display("FAIL clamp_addr: max rd_addr %0d want <= 1535", cap_max_addr); end
      n_chk++; if (cap_en_ticks != 3096) begin n_fail++; $display("FAIL clamp_tx_en_len: got %0d want 3096", cap_en_ticks); end
   endtask

   task automatic test_tick_spacing();
      int len;
      int d;
      fill_random();
      len = int'($urandom_range(100, 20));
      build_model(len, 60);
      tick_gap = 2;
      send_frame(1'b1, len, 1'b1, 50);
      q1 = cap_q;
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL space2_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_busy_err != 0 || cap_sync_err != 0) begin n_fail++;
         $display("FAIL space2_busy: busy drops %0d off-tick changes %0d want 0/0", cap_busy_err, cap_sync_err); end
      tick_gap = 0;
      send_frame(1'b1, len, 1'b1, 50);
      d = (q1.size() != cap_q.size()) ? 1 : 0;
      foreach (q1[i]) if (i >= cap_q.size() || q1[i] !== cap_q[i]) d++;
      n_chk++; if (d != 0) begin n_fail++; $display("FAIL spacing_equal: %0d diffs between gap-2 and random-gap streams", d); end
      n_chk++; if (stream_diffs() != 0) begin n_fail++;
         $display("FAIL spacerand_stream: %0d diffs, got %0d nibbles want %0d", stream_diffs(), cap_q.size(), exp_q.size()); end
      n_chk++; if (cap_busy_err != 0 || !cap_done) begin n_fail++;
         $display("FAIL spacerand_busy: busy drops %0d done %0d want 0/1", cap_busy_err, cap_done); end
   endtask

   task automatic test_back_to_back();
      fill_random();
      tick_gap = 2;
      send_frame(1'b1, 30, 1'b1, 0);
      n_chk++; if (m_busy !== 1'b0 || !cap_done) begin n_fail++;
         $display("FAIL b2b_busy_at_done: busy %b done %0d want 0/1", m_busy, cap_done); end
      drive_start(1'b1, 25);
      @(posedge clk); #1;
      n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_with_done: busy %b want 0", m_busy); end
      @(posedge clk); #1;
      ifb.start = 1'b0;
      n_chk++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_after_done: busy %b want 1", m_busy); end
      send_frame(1'b1, 25, 1'b0, 0);
      build_model(25, 60);
      n_chk++; if (!cap_done || stream_diffs() != 0) begin n_fail++;
         $display("FAIL b2b_stream: done %0d diffs %0d want 1/0", cap_done, stream_diffs()); end
   endtask

   task automatic test_reset_mid();
      int t, c, dn, en;
      fill_random();
      tick_gap = 2;
      sel = 1'b1;
      @(posedge clk); #1;
      drive_start(1'b1, 100);
      @(posedge clk); #1;
      ifb.start = 1'b0;
      t = 0; c = 0;
      while (t < 60 && c < 1000) begin
         @(posedge clk); #1;
         c++;
         if (tick) t++;
      end
      n_chk++; if (m_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: tx_en %b want 1 before reset", m_en); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (m_en !== 1'b0 || m_busy !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_async: tx_en %b busy %b want 0/0", m_en, m_busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0; en = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (m_done) dn++;
         if (m_en) en++;
      end
      n_chk++; if (dn != 0 || en != 0) begin n_fail++;
         $display("FAIL rstmid_quiet: done %0d tx_en %0d cycles want 0/0", dn, en); end
      send_frame(1'b1, 50, 1'b1, 0);
      build_model(50, 60);
      n_chk++; if (!cap_done || stream_diffs() != 0) begin n_fail++;
         $display("FAIL rstmid_next: done %0d diffs %0d want 1/0", cap_done, stream_diffs()); end
   endtask

   initial begin
      fill_random();
      test_reset();
      test_check_vector();
      test_short_pad();
      test_zero_len();
      test_clamp();
      test_tick_spacing();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
